// File: rtl/store_buffer.sv
// store_buffer: in-order write buffer between the pipeline memory stage and data memory,
// with youngest-match store-to-load forwarding.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     memwrite,
  input  logic [AW-1:0]            dataadr,
  input  logic [DW-1:0]            writedata,
  input  logic [DW/8-1:0]          wstrb,
  output logic                     stall,
  output logic                     mem_valid,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [DW/8-1:0]          mem_wstrb,
  input  logic                     mem_ready,
  input  logic [AW-1:0]            ld_addr,
  output logic                     ld_hit,
  output logic [DW-1:0]            ld_data,
  output logic                     ld_conflict,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0]   addr_q [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [DW/8-1:0] strb_q [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, sel, idx;
  logic            push, pop, found, full_strb;
  assign empty     = count == '0;
  assign stall     = count == CW'(DEPTH);
  assign mem_valid = !empty;
  assign push      = memwrite && !stall;
  assign pop       = mem_valid && mem_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  // Payload needs no reset: validity comes solely from count.
  always_ff @(posedge clk)
    if (push) begin
      addr_q[wr_ptr] <= dataadr;
      data_q[wr_ptr] <= writedata;
      strb_q[wr_ptr] <= wstrb;
    end
  assign mem_addr  = mem_valid ? addr_q[rd_ptr] : '0;
  assign mem_wdata = mem_valid ? data_q[rd_ptr] : '0;
  assign mem_wstrb = mem_valid ? strb_q[rd_ptr] : '0;
  // Scan oldest to youngest so the last match wins.
  always_comb begin
    found = 1'b0;
    sel   = rd_ptr;
    idx   = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count && addr_q[idx][AW-1:2] == ld_addr[AW-1:2]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end
  assign full_strb   = &strb_q[sel];
  assign ld_hit      = found && full_strb;
  assign ld_conflict = found && !full_strb;
  assign ld_data     = ld_hit ? data_q[sel] : '0;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_store_buffer;
  logic        clk = 0, rst = 1, memwrite = 0, mem_ready = 0;
  logic [31:0] dataadr = 0, writedata = 0, ld_addr = 0;
  logic [3:0]  wstrb = 0;
  logic        stall, mem_valid, ld_hit, ld_conflict, empty;
  logic [31:0] mem_addr, mem_wdata, ld_data;
  logic [3:0]  mem_wstrb;
  logic [2:0]  count;
  typedef struct packed {logic [31:0] a; logic [31:0] d; logic [3:0] s;} ent_t;
  ent_t q[$];
  int passed = 0, total = 0;

  store_buffer dut (
    .clk(clk), .rst(rst), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .wstrb(wstrb), .stall(stall), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict), .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  task automatic tick();
    bit do_pop, do_push;
    do_pop  = q.size() != 0 && mem_ready;
    do_push = memwrite && q.size() < 4;
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{a: dataadr, d: writedata, s: wstrb});
    @(negedge clk);
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    memwrite = 1; dataadr = a; writedata = d; wstrb = s;
    tick();
    memwrite = 0;
  endtask

  function automatic void model_ld(input logic [31:0] la, output bit h, output bit c, output logic [31:0] d);
    h = 0; c = 0; d = 0;
    for (int k = q.size() - 1; k >= 0; k--)
      if (q[k].a[31:2] == la[31:2]) begin
        h = q[k].s == 4'hF;
        c = !h;
        d = h ? q[k].d : 32'h0;
        break;
      end
  endfunction

  task automatic pulse_reset();
    #2 rst = 1;
    #1 q.delete();
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b exp 1", empty); else passed++;
    total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d exp 0", count); else passed++;
    total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b exp 0", stall); else passed++;
    total++; if (mem_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b exp 0", mem_valid); else passed++;
    total++; if ({ld_hit, ld_conflict} !== 2'b00) $display("FAIL reset_ld: got %b exp 00", {ld_hit, ld_conflict}); else passed++;
    total++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) $display("FAIL reset_mem_port: got %h exp 0", {mem_addr, mem_wdata, mem_wstrb}); else passed++;
    rst = 0;
  endtask

  task automatic test_stream();
    logic [31:0] d;
    mem_ready = 1;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      push_store(100 + 4 * i, d, 4'hF);
      total++;
      if ({mem_valid, mem_addr, mem_wdata, count} !== {1'b1, 32'(100 + 4 * i), d, 3'd1})
        $display("FAIL stream_%0d: got v=%b a=%0d d=%h c=%0d exp v=1 a=%0d d=%h c=1", i, mem_valid, mem_addr, mem_wdata, count, 100 + 4 * i, d);
      else passed++;
    end
    tick();
    total++; if (empty !== 1'b1) $display("FAIL stream_drained: got empty=%b exp 1", empty); else passed++;
  endtask

  task automatic test_full();
    mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      push_store(200 + 4 * i, i + 1, 4'hF);
      total++;
      if ({stall, count} !== {i >= 3, 3'(i >= 3 ? 4 : i + 1)})
        $display("FAIL full_push_%0d: got stall=%b count=%0d exp stall=%b count=%0d", i, stall, count, i >= 3, i >= 3 ? 4 : i + 1);
      else passed++;
    end
    mem_ready = 1;
    for (int j = 0; j < 4; j++) begin
      total++;
      if ({mem_valid, mem_addr, mem_wdata} !== {1'b1, 32'(200 + 4 * j), 32'(j + 1)})
        $display("FAIL full_drain_%0d: got v=%b a=%0d d=%0d exp v=1 a=%0d d=%0d", j, mem_valid, mem_addr, mem_wdata, 200 + 4 * j, j + 1);
      else passed++;
      tick();
    end
    total++; if (empty !== 1'b1) $display("FAIL full_fifth_dropped: got empty=%b exp 1", empty); else passed++;
  endtask

  task automatic test_push_pop_full();
    mem_ready = 0;
    for (int i = 0; i < 4; i++) push_store(300 + 4 * i, $urandom, 4'hF);
    total++; if (stall !== 1'b1) $display("FAIL ppf_stall: got %b exp 1", stall); else passed++;
    memwrite = 1; dataadr = 32'h999; writedata = 32'h5A5A; wstrb = 4'hF; mem_ready = 1;
    tick();
    memwrite = 0;
    total++;
    if ({count, stall, mem_addr} !== {3'd3, 1'b0, 32'd304})
      $display("FAIL ppf_pop_only: got count=%0d stall=%b a=%0d exp count=3 stall=0 a=304", count, stall, mem_addr);
    else passed++;
    for (int j = 1; j < 4; j++) begin
      total++;
      if (mem_addr !== 32'(300 + 4 * j)) $display("FAIL ppf_order_%0d: got a=%0d exp %0d", j, mem_addr, 300 + 4 * j);
      else passed++;
      tick();
    end
    total++; if (empty !== 1'b1) $display("FAIL ppf_dropped: got empty=%b exp 1", empty); else passed++;
  endtask

  task automatic test_forward();
    mem_ready = 0;
    push_store(100, 25, 4'hF);
    push_store(100, 7, 4'hF);
    ld_addr = 102; #1;
    total++;
    if ({ld_hit, ld_conflict, ld_data} !== {2'b10, 32'd7})
      $display("FAIL fwd_youngest: got hit=%b conf=%b d=%0d exp hit=1 conf=0 d=7", ld_hit, ld_conflict, ld_data);
    else passed++;
    push_store(104, 32'hABCD, 4'h3);
    ld_addr = 104; #1;
    total++;
    if ({ld_hit, ld_conflict} !== 2'b01) $display("FAIL fwd_partial: got hit=%b conf=%b exp hit=0 conf=1", ld_hit, ld_conflict);
    else passed++;
    ld_addr = 108; #1;
    total++;
    if ({ld_hit, ld_conflict, ld_data} !== 34'h0) $display("FAIL fwd_miss: got hit=%b conf=%b d=%h exp all 0", ld_hit, ld_conflict, ld_data);
    else passed++;
    memwrite = 1; dataadr = 108; writedata = 55; wstrb = 4'hF; #1;
    total++;
    if (ld_hit !== 1'b0) $display("FAIL fwd_push_excluded: got hit=%b exp 0", ld_hit); else passed++;
    tick();
    memwrite = 0; #1;
    total++;
    if ({ld_hit, ld_data} !== {1'b1, 32'd55}) $display("FAIL fwd_after_push: got hit=%b d=%0d exp hit=1 d=55", ld_hit, ld_data);
    else passed++;
    ld_addr = 100; mem_ready = 1; #1;
    total++;
    if ({ld_hit, ld_data} !== {1'b1, 32'd7}) $display("FAIL fwd_during_pop: got hit=%b d=%0d exp hit=1 d=7", ld_hit, ld_data);
    else passed++;
    mem_ready = 0;
    pulse_reset();
  endtask

  task automatic test_reset_mid();
    int writes;
    logic [31:0] got_addr;
    mem_ready = 0;
    for (int i = 0; i < 3; i++) push_store(400 + 4 * i, $urandom, 4'hF);
    total++; if (count !== 3'd3) $display("FAIL rstmid_fill: got count=%0d exp 3", count); else passed++;
    #2 rst = 1;
    #1;
    total++;
    if ({empty, mem_valid, count} !== {1'b1, 1'b0, 3'd0})
      $display("FAIL rstmid_clear: got empty=%b v=%b count=%0d exp empty=1 v=0 count=0", empty, mem_valid, count);
    else passed++;
    q.delete();
    rst = 0;
    @(negedge clk);
    mem_ready = 1;
    push_store(120, 32'h1234, 4'hF);
    writes = 0; got_addr = 0;
    for (int c = 0; c < 6; c++) begin
      if (mem_valid) begin writes++; got_addr = mem_addr; end
      tick();
    end
    total++;
    if (writes !== 1 || got_addr !== 32'd120)
      $display("FAIL rstmid_single_write: got writes=%0d a=%0d exp writes=1 a=120", writes, got_addr);
    else passed++;
  endtask

  task automatic test_random();
    bit h, c, ev;
    logic [31:0] d;
    ent_t head;
    for (int n = 0; n < 400; n++) begin
      memwrite  = $urandom_range(0, 2) != 0;
      dataadr   = 32'h40 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
      writedata = $urandom;
      wstrb     = $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'hF;
      mem_ready = $urandom_range(0, 2) == 0;
      ld_addr   = 32'h40 + ($urandom_range(0, 4) << 2) + $urandom_range(0, 3);
      #1;
      ev   = q.size() != 0;
      head = ev ? q[0] : '0;
      model_ld(ld_addr, h, c, d);
      total++;
      if ({mem_valid, mem_addr, mem_wdata, mem_wstrb} !== {ev, head})
        $display("FAIL rnd_mem_%0d: got %b/%h/%h/%h exp %b/%h/%h/%h", n, mem_valid, mem_addr, mem_wdata, mem_wstrb, ev, head.a, head.d, head.s);
      else passed++;
      total++;
      if ({count, stall, empty} !== {3'(q.size()), q.size() == 4, q.size() == 0})
        $display("FAIL rnd_status_%0d: got count=%0d stall=%b empty=%b exp count=%0d", n, count, stall, empty, q.size());
      else passed++;
      total++;
      if ({ld_hit, ld_conflict} !== {h, c} || (!c && ld_data !== d))
        $display("FAIL rnd_ld_%0d: got hit=%b conf=%b d=%h exp hit=%b conf=%b d=%h", n, ld_hit, ld_conflict, ld_data, h, c, d);
      else passed++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_push_pop_full();
    test_forward();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
